data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 15 +
 rtl/data_mem_responder_ram_1rw.sv | 23 ++
 rtl/data_mem_responder.sv | 96 +++++++++
 tb/tb_data_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared state encoding, default sizing and response codes for the data memory responder
package data_mem_responder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_WAIT_STATES = 1;
  localparam logic RESP_OK = 1'b0;
  localparam logic RESP_ERR_RANGE = 1'b1;
  function automatic logic in_range(input logic [15:0] byte_addr, input int depth);
    return 32'(byte_addr[15:2]) < 32'(depth);
  endfunction
endpackage

// File: rtl/data_mem_responder_ram_1rw.sv
// ram_1rw: single-port synchronous word array; read data register is resettable, the array is not
module ram_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW = 10
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic          i_clr,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  // read data holds between reads; an out-of-range read returns zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_addr];
    else if (i_clr) o_rdata <= '0;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory slave for the CPU memory stage with a boot preload port
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_STATES = DEF_WAIT_STATES
)(
  input  logic        CK_REF,
  input  logic        int_rst_n,
  input  logic        REQ_VALID,
  input  logic        MEM_ACCESS_READ_WRN,
  input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
  input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
  output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
  output logic        RESP_VALID,
  output logic        RESP_ERR,
  output logic        STALL,
  input  logic        LOAD_EN,
  input  logic [15:0] LOAD_ADDR,
  input  logic [31:0] LOAD_DATA
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;
  logic r_rd, r_resp, r_err;
  logic w_accept, w_go, w_rd, w_inrng, w_load;
  logic [AW-1:0] w_ram_addr;
  assign w_accept = r_state == ST_IDLE && REQ_VALID;
  // zero wait states: the access uses the live bus at the accepting edge
  assign w_go = WAIT_STATES == 0 ? w_accept : r_state == ST_ACCESS;
  assign w_addr = WAIT_STATES == 0 ? MEM_ACCESS_ADDRESS_BUS : r_addr;
  assign w_rd = WAIT_STATES == 0 ? MEM_ACCESS_READ_WRN : r_rd;
  assign w_wdata = WAIT_STATES == 0 ? MEM_ACCESS_DATA_OUT_BUS : r_wdata;
  assign w_inrng = in_range(w_addr, DEPTH_WORDS);
  assign w_load = r_state == ST_IDLE && !REQ_VALID && LOAD_EN && in_range(LOAD_ADDR, DEPTH_WORDS);
  assign w_ram_addr = w_load ? AW'(LOAD_ADDR[15:2]) : AW'(w_addr[15:2]);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = w_accept && WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
        w_cnt_nxt = w_accept && WAIT_STATES > 0 ? CNT_LOAD : r_cnt;
      end
      ST_WAIT: begin
        w_state_nxt = r_cnt == 4'd0 ? ST_ACCESS : ST_WAIT;
        w_cnt_nxt = r_cnt == 4'd0 ? r_cnt : r_cnt - 4'd1;
      end
      ST_ACCESS: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CK_REF or negedge int_rst_n)
    if (!int_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  always_ff @(posedge CK_REF or negedge int_rst_n)
    if (!int_rst_n) begin
      r_addr <= '0;
      r_rd <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr <= MEM_ACCESS_ADDRESS_BUS;
      r_rd <= MEM_ACCESS_READ_WRN;
      r_wdata <= MEM_ACCESS_DATA_OUT_BUS;
    end
  always_ff @(posedge CK_REF or negedge int_rst_n)
    if (!int_rst_n) begin
      r_resp <= 1'b0;
      r_err <= RESP_OK;
    end else begin
      r_resp <= w_go;
      r_err <= w_go && !w_inrng ? RESP_ERR_RANGE : RESP_OK;
    end
  // preload and request never coincide: load needs IDLE with no request
  ram_1rw #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk(CK_REF),
    .rst_n(int_rst_n),
    .i_we(w_load || (w_go && !w_rd && w_inrng)),
    .i_re(w_go && w_rd && w_inrng),
    .i_clr(w_go && w_rd && !w_inrng),
    .i_addr(w_ram_addr),
    .i_wdata(w_load ? LOAD_DATA : w_wdata),
    .o_rdata(MEM_ACCESS_DATA_IN_BUS)
  );
  assign STALL = r_state != ST_IDLE;
  assign RESP_VALID = r_resp;
  assign RESP_ERR = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responders (0, 2 and 3 wait states) checked against a word-array model
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[3], req[3], rd[3], ld_en[3], rv[3], re[3], st[3];
  logic [15:0] addr[3], ld_addr[3];
  logic [31:0] wd[3], ld_data[3], dout[3];
  logic [31:0] mm[3][1024];
  logic [31:0] md[3];
  int checks = 0;
  int errors = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
      .CK_REF(clk),
      .int_rst_n(rst_n[g]),
      .REQ_VALID(req[g]),
      .MEM_ACCESS_READ_WRN(rd[g]),
      .MEM_ACCESS_ADDRESS_BUS(addr[g]),
      .MEM_ACCESS_DATA_OUT_BUS(wd[g]),
      .MEM_ACCESS_DATA_IN_BUS(dout[g]),
      .RESP_VALID(rv[g]),
      .RESP_ERR(re[g]),
      .STALL(st[g]),
      .LOAD_EN(ld_en[g]),
      .LOAD_ADDR(ld_addr[g]),
      .LOAD_DATA(ld_data[g])
    );
  end
  function automatic int nw(int d);
    return d == 0 ? 0 : d + 1;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load_word(int d, logic [15:0] a, logic [31:0] v);
    @(negedge clk);
    ld_en[d] = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    @(posedge clk);
    if (a[15:2] < 14'd1024) mm[d][a[11:2]] = v;
    #1 ld_en[d] = 1'b0;
  endtask
  task automatic do_req(int d, logic r, logic [15:0] a, logic [31:0] w);
    int lat, stalls;
    logic inr;
    @(negedge clk);
    req[d] = 1'b1;
    rd[d] = r;
    addr[d] = a;
    wd[d] = w;
    @(posedge clk);
    inr = a[15:2] < 14'd1024;
    if (r) md[d] = inr ? mm[d][a[11:2]] : 32'd0;
    else if (inr) mm[d][a[11:2]] = w;
    #1 req[d] = 1'b0;
    addr[d] = 16'($urandom);
    wd[d] = $urandom;
    rd[d] = 1'($urandom);
    lat = 0;
    stalls = 0;
    do begin
      @(negedge clk);
      lat++;
      stalls += int'(st[d]);
    end while (!rv[d] && lat < 40);
    chk($sformatf("latency d%0d a%h", d, a), lat, nw(d) == 0 ? 1 : nw(d) + 2);
    chk($sformatf("stall cycles d%0d a%h", d, a), stalls, nw(d) == 0 ? 0 : nw(d) + 1);
    chk($sformatf("resp_err d%0d a%h", d, a), 32'(re[d]), 32'(!inr));
    chk($sformatf("data_in d%0d a%h", d, a), dout[d], md[d]);
    @(negedge clk);
    chk($sformatf("resp single pulse d%0d", d), 32'(rv[d]), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    int n, k, idx;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      req[d] = 1'b0;
      rd[d] = 1'b0;
      ld_en[d] = 1'b0;
      addr[d] = '0;
      wd[d] = '0;
      ld_addr[d] = '0;
      ld_data[d] = '0;
      md[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset resp_valid d%0d", d), 32'(rv[d]), 32'd0);
      chk($sformatf("reset resp_err d%0d", d), 32'(re[d]), 32'd0);
      chk($sformatf("reset stall d%0d", d), 32'(st[d]), 32'd0);
      chk($sformatf("reset data_in d%0d", d), dout[d], 32'd0);
    end
    // first edge after reset release accepts a request
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    req[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0040; wd[0] = 32'h0BAD_0001;
    req[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0040; wd[1] = 32'h0BAD_0002;
    @(posedge clk);
    mm[0][16] = 32'h0BAD_0001;
    mm[1][16] = 32'h0BAD_0002;
    #1 req[0] = 1'b0;
    req[1] = 1'b0;
    chk("first edge stall d1", 32'(st[1]), 32'd1);
    @(negedge clk);
    chk("first edge resp d0", 32'(rv[0]), 32'd1);
    repeat (6) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) if (i != 16) load_word(d, 16'(i * 4), $urandom);
      load_word(d, 16'(1020 * 4), $urandom);
      load_word(d, 16'(1023 * 4), $urandom);
    end
    do_req(0, 1'b1, 16'h0040, 32'd0);
    do_req(1, 1'b1, 16'h0040, 32'd0);
    // back-to-back write then read with no wait states
    @(negedge clk);
    req[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0010; wd[0] = 32'hCAFE_F00D;
    @(posedge clk);
    mm[0][4] = 32'hCAFE_F00D;
    #1 rd[0] = 1'b1;
    wd[0] = 32'd0;
    @(negedge clk);
    chk("b2b write resp", 32'(rv[0]), 32'd1);
    chk("b2b write stall", 32'(st[0]), 32'd0);
    @(posedge clk);
    md[0] = mm[0][4];
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk("b2b read resp", 32'(rv[0]), 32'd1);
    chk("b2b read stall", 32'(st[0]), 32'd0);
    chk("b2b read data", dout[0], 32'hCAFE_F00D);
    @(negedge clk);
    chk("b2b idle", 32'(rv[0]), 32'd0);
    load_word(2, 16'h0004, 32'h1234_5678);
    do_req(2, 1'b1, 16'h0004, 32'd0);
    do_req(2, 1'b0, 16'h1000, 32'hDEAD_BEEF);
    do_req(2, 1'b1, 16'h1000, 32'd0);
    do_req(2, 1'b1, 16'h0000, 32'd0);
    // request during stall is ignored
    @(negedge clk);
    req[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0014;
    @(posedge clk);
    md[1] = mm[1][5];
    #1 addr[1] = 16'h0018;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) req[1] = 1'b0;
      n += int'(rv[1]);
    end
    chk("ignored req resp count", n, 1);
    chk("ignored req data", dout[1], md[1]);
    // reset during wait abandons the write
    @(negedge clk);
    req[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0008; wd[1] = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    chk("abandon in wait", 32'(st[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk("abandon reset stall", 32'(st[1]), 32'd0);
    chk("abandon reset resp", 32'(rv[1]), 32'd0);
    chk("abandon reset data", dout[1], 32'd0);
    md[1] = 32'd0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(rv[1]);
    end
    chk("abandon stray resp", n, 0);
    do_req(1, 1'b1, 16'h0008, 32'd0);
    // load alongside a request is dropped; a lone load is visible
    @(negedge clk);
    req[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'h0024;
    ld_en[0] = 1'b1; ld_addr[0] = 16'h0028; ld_data[0] = 32'h5A5A_0001;
    @(posedge clk);
    md[0] = mm[0][9];
    #1 req[0] = 1'b0;
    ld_en[0] = 1'b0;
    @(negedge clk);
    chk("load+req resp", 32'(rv[0]), 32'd1);
    chk("load+req data", dout[0], md[0]);
    do_req(0, 1'b1, 16'h0028, 32'd0);
    load_word(0, 16'h0028, 32'h5A5A_0002);
    do_req(0, 1'b1, 16'h0028, 32'd0);
    load_word(0, 16'hFFF0, 32'h0000_DEAD);
    do_req(0, 1'b1, 16'(1020 * 4), 32'd0);
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 15; i++) begin
        k = $urandom_range(0, 9);
        idx = k < 8 ? k : (k == 8 ? 1023 : 1024 + $urandom_range(0, 15000));
        do_req(d, 1'($urandom), {idx[13:0], 2'($urandom)}, $urandom);
      end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
